demux_dispatch_ctrl: RTL and testbench
======================================

Name: demux_dispatch_ctrl

Overview:
- Sequencer for the 2-bit, 1-to-4 demultiplexer.
- Accepts 2-bit words from a single valid/ready source and picks a destination channel, either round-robin or directed by the source.
- Drives the demux data and select inputs, and presents a one-hot valid to the four downstream consumers.
- If the chosen consumer stalls for too long, drops the word, counts the drop and frees the path.

Parameters:
- DATA_W, 2, width of the data word and of the demux data path.
- TIMEOUT, 15, number of HOLD cycles without ch_ready before the word is dropped (legal range 1..255).
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; everything changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  source word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  source word.
- in_dest  in  2  requested channel, used only when mode=1.
- mode  in  1  0 = round-robin, 1 = directed by in_dest.
- ch_ready  in  4  per-channel consumer ready (bit 0 = W, 1 = X, 2 = Y, 3 = Z).
- ch_valid  out  4  one-hot valid to the consumer of the selected channel.
- dmx_a  out  DATA_W  data into the demux A input.
- dmx_sel  out  2  select into the demux SEL input.
- busy  out  1  high while in HOLD.
- drop_pulse  out  1  one-cycle pulse when a word is dropped on timeout.
- drop_count  out  DROP_W  saturating count of dropped words.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - state=IDLE, in_ready=1, ch_valid=0, dmx_a=0, dmx_sel=0, busy=0, drop_pulse=0, drop_count=0, rr_ptr=0, timer=0.
- Reset during HOLD discards the held word. No ch_valid is asserted on the cycle after reset.
- in_ready is combinational: 1 in IDLE, 0 in HOLD. Accept occurs on a clk edge with in_valid and in_ready both high.
- IDLE, on accept:
  - dmx_a <= in_data.
  - dest = in_dest if mode=1, else rr_ptr. dmx_sel <= dest.
  - timer <= 0, go to HOLD.
  - mode and in_dest are sampled only at accept; changes during HOLD are ignored.
- HOLD:
  - ch_valid = one-hot(dmx_sel), registered and stable for the whole HOLD.
  - dmx_a and dmx_sel are stable for the whole HOLD.
  - busy=1.
  - Latency: accept edge to ch_valid high is 1 cycle.
- HOLD exit on completion: ch_ready[dmx_sel]=1 at an edge transfers the word and returns to IDLE. ch_valid drops on the next cycle. ch_ready bits of unselected channels are ignored.
- HOLD timeout:
  - If ch_ready[dmx_sel]=0, timer increments.
  - When timer==TIMEOUT-1 and ch_ready[dmx_sel]=0, the word is dropped: drop_pulse=1 for exactly one cycle, drop_count increments (saturates at all-ones, no wrap), return to IDLE.
  - With TIMEOUT=15, ch_valid is therefore high for exactly 15 cycles.
- Same-edge ch_ready and timeout expiry: the transfer wins; no drop is counted.
- Round-robin pointer:
  - Advances only when a word accepted in mode=0 leaves HOLD (completed or dropped): rr_ptr <= dmx_sel+1 mod 4, so 3 wraps to 0.
  - Directed transfers do not move rr_ptr.
- Throughput: at most one word every 2 cycles (IDLE, HOLD). No bypass.
- dmx_a and dmx_sel hold their last values in IDLE. ch_valid=0 in IDLE guarantees the demux outputs are not consumed.
- Invariants:
  - ch_valid is 0 or one-hot, never more than one bit.
  - ch_valid is nonzero only when busy=1.
  - in_ready and busy are mutually exclusive.

Test Plan:
1. Reset and round-robin order: after reset, mode=0, ch_ready=4'b1111, send words 2'b10, 01, 11, 00, 10 back-to-back (in_valid held).
   - ch_valid sequence 0001, 0010, 0100, 1000, 0001.
   - dmx_sel sequence 0, 1, 2, 3, 0; dmx_a matches each word.
   - Each word takes 2 cycles.
2. Directed mode with stall: mode=1, in_dest=2, in_data=2'b11, ch_ready=0 for 3 cycles, then 4'b0100.
   - ch_valid=0100 for 4 cycles, dmx_sel=2, in_ready=0 throughout.
   - Returns to IDLE; rr_ptr unchanged.
3. Timeout drop: mode=1, in_dest=3, ch_ready=0 permanently, TIMEOUT=15.
   - ch_valid=1000 for 15 cycles, then drop_pulse high for 1 cycle.
   - drop_count 0→1, in_ready returns to 1.
4. Ready and timeout on the same edge: assert ch_ready[sel] exactly on the 15th HOLD cycle.
   - Transfer completes, drop_pulse stays 0, drop_count unchanged.
5. Drop counter saturation: with DROP_W=2, force 5 consecutive timeouts.
   - drop_count reads 1, 2, 3, 3, 3.
   - drop_pulse fires all 5 times.
6. Reset mid-operation: rst_n=0 for 1 cycle during HOLD on channel 1.
   - Next cycle: ch_valid=0, busy=0, in_ready=1, dmx_sel=0, rr_ptr=0.
   - The next mode=0 word goes to channel 0.

Source files
------------

// File: rtl/demux_dispatch_if.sv
// demux_dispatch_if
// Bundles the source handshake, the per-channel consumer handshake, the
// demux drive signals and the drop status of the demux dispatch sequencer.
//   slave  : the dispatch controller (consumes in_*, mode, ch_ready;
//            drives in_ready, ch_valid, dmx_a, dmx_sel, busy, drop_*)
//   master : the surrounding system / testbench (the opposite directions)
// Signals:
//   in_valid, in_ready, in_data[DATA_W], in_dest[2], mode  - source side
//   ch_ready[4], ch_valid[4]                               - consumer side
//   dmx_a[DATA_W], dmx_sel[2]                              - demux inputs
//   busy, drop_pulse, drop_count[DROP_W]                   - status
interface demux_dispatch_if #(
  parameter int DATA_W = 2,
  parameter int DROP_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_dest;
  logic              mode;
  logic [3:0]        ch_ready;
  logic [3:0]        ch_valid;
  logic [DATA_W-1:0] dmx_a;
  logic [1:0]        dmx_sel;
  logic              busy;
  logic              drop_pulse;
  logic [DROP_W-1:0] drop_count;

  modport slave (
    input  in_valid, in_data, in_dest, mode, ch_ready,
    output in_ready, ch_valid, dmx_a, dmx_sel, busy, drop_pulse, drop_count
  );

  modport master (
    output in_valid, in_data, in_dest, mode, ch_ready,
    input  in_ready, ch_valid, dmx_a, dmx_sel, busy, drop_pulse, drop_count
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl
// Sequencer for a DATA_W-bit 1-to-4 demultiplexer. Accepts one word from a
// valid/ready source, picks a channel (round-robin or directed by in_dest),
// drives the demux A/SEL inputs and raises a one-hot valid towards the
// chosen consumer until it is taken. A consumer that stalls for TIMEOUT
// HOLD cycles loses the word; the drop is pulsed and counted (saturating).
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - demux_dispatch_if.slave (source, consumer, demux and status)
module demux_dispatch_ctrl #(
  parameter int DATA_W  = 2,
  parameter int TIMEOUT = 15,
  parameter int DROP_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_dispatch_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] dmx_a_q;
  logic [1:0]        dmx_sel_q;
  logic [3:0]        ch_valid_q;
  logic [1:0]        rr_ptr;
  logic              rr_word;
  logic [7:0]        timer;
  logic              drop_pulse_q;
  logic [DROP_W-1:0] drop_count_q;

  logic       accept;
  logic [1:0] dest;
  logic       sel_ready;
  logic       expire;
  logic       done;
  logic       drop;
  logic       leave;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign dest      = bus.mode ? bus.in_dest : rr_ptr;
  assign sel_ready = bus.ch_ready[dmx_sel_q];
  assign expire    = (timer == TIMER_LAST);
  // A ready on the expiry edge still counts as a transfer, so drop is
  // qualified by !sel_ready.
  assign done      = (state == HOLD) && sel_ready;
  assign drop      = (state == HOLD) && !sel_ready && expire;
  assign leave     = done || drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = HOLD;
      HOLD: if (leave)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: the demux inputs are captured at accept and held until the
  // next accept; ch_valid is registered so it is clean for the whole HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmx_a_q      <= '0;
      dmx_sel_q    <= '0;
      ch_valid_q   <= '0;
      rr_ptr       <= '0;
      rr_word      <= 1'b0;
      timer        <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      drop_pulse_q <= drop;
      if (accept) begin
        dmx_a_q    <= bus.in_data;
        dmx_sel_q  <= dest;
        ch_valid_q <= 4'b0001 << dest;
        rr_word    <= !bus.mode;
        timer      <= '0;
      end else if (leave) begin
        ch_valid_q <= '0;
        // Only round-robin words advance the pointer, completed or dropped.
        if (rr_word) begin
          rr_ptr <= dmx_sel_q + 2'd1;
        end
      end else if (state == HOLD) begin
        timer <= timer + 8'd1;
      end
      if (drop && (drop_count_q != {DROP_W{1'b1}})) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state == HOLD);
  assign bus.ch_valid   = ch_valid_q;
  assign bus.dmx_a      = dmx_a_q;
  assign bus.dmx_sel    = dmx_sel_q;
  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl
// Directed bench for demux_dispatch_ctrl (DATA_W=2, TIMEOUT=15, DROP_W=2).
// Each vector holds the inputs driven for one cycle and the outputs expected
// during that same cycle; inputs change on the falling edge and outputs are
// sampled shortly after, before the next rising edge.
module tb_demux_dispatch_ctrl;

  typedef struct {
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_data;
    logic [1:0] in_dest;
    logic       mode;
    logic [3:0] ch_ready;
    logic       exp_ready;
    logic [3:0] exp_valid;
    logic [1:0] exp_a;
    logic [1:0] exp_sel;
    logic       exp_busy;
    logic       exp_pulse;
    logic [1:0] exp_count;
  } vec_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  demux_dispatch_if #(.DATA_W(2), .DROP_W(2)) bus ();

  demux_dispatch_ctrl #(.DATA_W(2), .TIMEOUT(15), .DROP_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, input logic v, input logic [1:0] d, input logic [1:0] dst,
    input logic m, input logic [3:0] rdy, input logic er, input logic [3:0] ev,
    input logic [1:0] ea, input logic [1:0] es, input logic eb, input logic ep,
    input logic [1:0] ec);
    vec_t r;
    r.rst_n = rst;  r.in_valid = v;  r.in_data = d;  r.in_dest = dst;
    r.mode = m;     r.ch_ready = rdy;
    r.exp_ready = er; r.exp_valid = ev; r.exp_a = ea; r.exp_sel = es;
    r.exp_busy = eb;  r.exp_pulse = ep; r.exp_count = ec;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n        = v.rst_n;
    bus.in_valid = v.in_valid;
    bus.in_data  = v.in_data;
    bus.in_dest  = v.in_dest;
    bus.mode     = v.mode;
    bus.ch_ready = v.ch_ready;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    logic inv_ok;
    #1;
    cmp({tag, ".in_ready"},   8'(bus.in_ready),   8'(v.exp_ready));
    cmp({tag, ".ch_valid"},   8'(bus.ch_valid),   8'(v.exp_valid));
    cmp({tag, ".dmx_a"},      8'(bus.dmx_a),      8'(v.exp_a));
    cmp({tag, ".dmx_sel"},    8'(bus.dmx_sel),    8'(v.exp_sel));
    cmp({tag, ".busy"},       8'(bus.busy),       8'(v.exp_busy));
    cmp({tag, ".drop_pulse"}, 8'(bus.drop_pulse), 8'(v.exp_pulse));
    cmp({tag, ".drop_count"}, 8'(bus.drop_count), 8'(v.exp_count));
    inv_ok = $onehot0(bus.ch_valid) && ((bus.ch_valid == 4'b0) || bus.busy)
             && (bus.in_ready != bus.busy);
    cmp({tag, ".invariant"}, 8'(inv_ok), 8'd1);
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  vec_t tbl [19];

  initial begin
    logic [1:0] prev_a;
    logic [1:0] prev_sel;
    logic [1:0] prev_cnt;
    logic [1:0] data;
    logic [1:0] dst;
    logic [3:0] oh;
    compared   = 0;
    mismatched = 0;

    // Round-robin order (rows 0-10), then directed with stall (rows 11-15),
    // then a round-robin word showing the pointer was left alone (16-18).
    tbl[0]  = mk(1,1,2'b10,2'd0,0,4'hF, 1,4'b0000,2'b00,2'd0,0,0,2'd0);
    tbl[1]  = mk(1,1,2'b01,2'd0,0,4'hF, 0,4'b0001,2'b10,2'd0,1,0,2'd0);
    tbl[2]  = mk(1,1,2'b01,2'd0,0,4'hF, 1,4'b0000,2'b10,2'd0,0,0,2'd0);
    tbl[3]  = mk(1,1,2'b11,2'd0,0,4'hF, 0,4'b0010,2'b01,2'd1,1,0,2'd0);
    tbl[4]  = mk(1,1,2'b11,2'd0,0,4'hF, 1,4'b0000,2'b01,2'd1,0,0,2'd0);
    tbl[5]  = mk(1,1,2'b00,2'd0,0,4'hF, 0,4'b0100,2'b11,2'd2,1,0,2'd0);
    tbl[6]  = mk(1,1,2'b00,2'd0,0,4'hF, 1,4'b0000,2'b11,2'd2,0,0,2'd0);
    tbl[7]  = mk(1,1,2'b10,2'd0,0,4'hF, 0,4'b1000,2'b00,2'd3,1,0,2'd0);
    tbl[8]  = mk(1,1,2'b10,2'd0,0,4'hF, 1,4'b0000,2'b00,2'd3,0,0,2'd0);
    tbl[9]  = mk(1,0,2'b00,2'd0,0,4'hF, 0,4'b0001,2'b10,2'd0,1,0,2'd0);
    tbl[10] = mk(1,0,2'b00,2'd0,0,4'hF, 1,4'b0000,2'b10,2'd0,0,0,2'd0);
    tbl[11] = mk(1,1,2'b11,2'd2,1,4'h0, 1,4'b0000,2'b10,2'd0,0,0,2'd0);
    tbl[12] = mk(1,1,2'b00,2'd0,0,4'h0, 0,4'b0100,2'b11,2'd2,1,0,2'd0);
    tbl[13] = mk(1,0,2'b00,2'd0,0,4'b1011, 0,4'b0100,2'b11,2'd2,1,0,2'd0);
    tbl[14] = mk(1,0,2'b00,2'd0,0,4'h0, 0,4'b0100,2'b11,2'd2,1,0,2'd0);
    tbl[15] = mk(1,0,2'b00,2'd0,0,4'b0100, 0,4'b0100,2'b11,2'd2,1,0,2'd0);
    tbl[16] = mk(1,1,2'b01,2'd0,0,4'hF, 1,4'b0000,2'b11,2'd2,0,0,2'd0);
    tbl[17] = mk(1,0,2'b00,2'd0,0,4'hF, 0,4'b0010,2'b01,2'd1,1,0,2'd0);
    tbl[18] = mk(1,0,2'b00,2'd0,0,4'hF, 1,4'b0000,2'b01,2'd1,0,0,2'd0);

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dest  = '0;
    bus.mode     = 1'b0;
    bus.ch_ready = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 19; i++) begin
      runVec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Timeout drop on channel 3; unselected ready bits must not help.
    runVec(mk(1,1,2'b10,2'd3,1,4'h0, 1,4'b0000,2'b01,2'd1,0,0,2'd0), "t3.acc");
    for (int i = 0; i < 15; i++) begin
      runVec(mk(1,0,2'b00,2'd0,0,4'b0111, 0,4'b1000,2'b10,2'd3,1,0,2'd0),
             $sformatf("t3.hold%0d", i));
    end
    runVec(mk(1,0,2'b00,2'd0,0,4'h0, 1,4'b0000,2'b10,2'd3,0,1,2'd1), "t3.drop");
    runVec(mk(1,0,2'b00,2'd0,0,4'h0, 1,4'b0000,2'b10,2'd3,0,0,2'd1), "t3.after");

    // Ready arrives on the same edge the timer expires: transfer wins.
    runVec(mk(1,1,2'b11,2'd1,1,4'h0, 1,4'b0000,2'b10,2'd3,0,0,2'd1), "t4.acc");
    for (int i = 0; i < 14; i++) begin
      runVec(mk(1,0,2'b00,2'd0,0,4'h0, 0,4'b0010,2'b11,2'd1,1,0,2'd1),
             $sformatf("t4.hold%0d", i));
    end
    runVec(mk(1,0,2'b00,2'd0,0,4'b0010, 0,4'b0010,2'b11,2'd1,1,0,2'd1), "t4.last");
    runVec(mk(1,0,2'b00,2'd0,0,4'h0, 1,4'b0000,2'b11,2'd1,0,0,2'd1), "t4.idle");
    runVec(mk(1,0,2'b00,2'd0,0,4'h0, 1,4'b0000,2'b11,2'd1,0,0,2'd1), "t4.after");

    // Reset from IDLE clears counter and pointer before the saturation run.
    runVec(mk(0,0,2'b00,2'd0,0,4'h0, 1,4'b0000,2'b11,2'd1,0,0,2'd1), "t5.rst");
    runVec(mk(1,0,2'b00,2'd0,0,4'h0, 1,4'b0000,2'b00,2'd0,0,0,2'd0), "t5.rstval");

    // Five round-robin timeouts: channels 0,1,2,3,0; count 1,2,3,3,3.
    prev_a   = 2'b00;
    prev_sel = 2'd0;
    prev_cnt = 2'd0;
    for (int k = 0; k < 5; k++) begin
      data = 2'(k + 1);
      dst  = 2'(k % 4);
      oh   = 4'b0001 << dst;
      runVec(mk(1,1,data,2'd3,0,4'h0, 1,4'b0000,prev_a,prev_sel,0,0,prev_cnt),
             $sformatf("t5.acc%0d", k));
      for (int i = 0; i < 15; i++) begin
        runVec(mk(1,0,2'b00,2'd0,0,~oh, 0,oh,data,dst,1,0,prev_cnt),
               $sformatf("t5.w%0d.hold%0d", k, i));
      end
      prev_cnt = (k + 1 >= 3) ? 2'd3 : 2'(k + 1);
      runVec(mk(1,0,2'b00,2'd0,0,4'h0, 1,4'b0000,data,dst,0,1,prev_cnt),
             $sformatf("t5.drop%0d", k));
      prev_a   = data;
      prev_sel = dst;
    end

    // Reset during HOLD on channel 1 discards the word and the pointer.
    runVec(mk(1,1,2'b11,2'd0,0,4'h0, 1,4'b0000,2'b01,2'd0,0,0,2'd3), "t6.acc");
    runVec(mk(0,0,2'b00,2'd0,0,4'h0, 0,4'b0010,2'b11,2'd1,1,0,2'd3), "t6.rst");
    runVec(mk(1,1,2'b10,2'd3,0,4'hF, 1,4'b0000,2'b00,2'd0,0,0,2'd0), "t6.post");
    runVec(mk(1,0,2'b00,2'd0,0,4'hF, 0,4'b0001,2'b10,2'd0,1,0,2'd0), "t6.hold");
    runVec(mk(1,0,2'b00,2'd0,0,4'hF, 1,4'b0000,2'b10,2'd0,0,0,2'd0), "t6.idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
